game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/ttt_pkg.sv | 26 ++
 rtl/ttt_line_check.sv | 18 +
 rtl/game_sequencer.sv | 162 ++++++++++++++++
 tb/tb_game_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
// Boards are 9-bit masks, bit 0 = top-left cell, row-major.
package ttt_pkg;

    localparam int BOARD_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        EVAL_X,
        ENG_WAIT,
        EVAL_O,
        DONE
    } state_t;

    // Three rows, three columns, two diagonals.
    localparam logic [BOARD_W-1:0] LINES [0:7] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic is_onehot9(input logic [BOARD_W-1:0] v);
        return (v != '0) && ((v & (v - 9'd1)) == '0);
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Flags a board that fully covers at least one of the eight winning lines.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    output logic               win_o
);

    always_comb begin
        win_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board_i & LINES[i]) == LINES[i]) begin
                win_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Tic-tac-toe turn sequencer: accepts X moves, hands O turns to an external
// engine with a timeout, and keeps result flags and saturating scores.
//
//   state    | meaning
//   IDLE     | waiting for an X move (go)
//   EVAL_X   | check X line / full board after X move
//   ENG_WAIT | eng_req high, waiting for eng_ack or timeout
//   EVAL_O   | check O line / full board after O move
//   DONE     | game over (result or fault), waits for new_game
module game_sequencer
    import ttt_pkg::*;
#(
    parameter int ENG_TIMEOUT = 15,
    parameter int SCORE_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic [BOARD_W-1:0] xin,
    input  logic               new_game,
    output logic               eng_req,
    input  logic               eng_ack,
    input  logic [BOARD_W-1:0] eng_move,
    output logic [BOARD_W-1:0] x_board,
    output logic [BOARD_W-1:0] o_board,
    output logic               busy,
    output logic               bad_move,
    output logic               win_game,
    output logic               lose_game,
    output logic               draw_game,
    output logic               eng_fault,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses,
    output logic [SCORE_W-1:0] draws
);

    localparam int             TW       = $clog2(ENG_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(ENG_TIMEOUT - 1);

    state_t               state_q;
    logic [BOARD_W-1:0]   x_q, o_q;
    logic                 req_q, bad_q, win_q, lose_q, draw_q, fault_q;
    logic [SCORE_W-1:0]   wins_q, losses_q, draws_q;
    logic [TW-1:0]        tmo_q;

    logic x_win, o_win, full, x_legal, o_legal;

    ttt_line_check u_x_line (.board_i(x_q), .win_o(x_win));
    ttt_line_check u_o_line (.board_i(o_q), .win_o(o_win));

    assign full    = &(x_q | o_q);
    assign x_legal = is_onehot9(xin) && ((xin & (x_q | o_q)) == '0);
    assign o_legal = is_onehot9(eng_move) && ((eng_move & (x_q | o_q)) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            o_q      <= '0;
            req_q    <= 1'b0;
            bad_q    <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            draw_q   <= 1'b0;
            fault_q  <= 1'b0;
            wins_q   <= '0;
            losses_q <= '0;
            draws_q  <= '0;
            tmo_q    <= '0;
        end else begin
            bad_q <= 1'b0;
            if (new_game) begin
                // Scores deliberately survive a new game.
                state_q <= IDLE;
                x_q     <= '0;
                o_q     <= '0;
                req_q   <= 1'b0;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
                draw_q  <= 1'b0;
                fault_q <= 1'b0;
                tmo_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (go) begin
                            if (x_legal) begin
                                x_q     <= x_q | xin;
                                state_q <= EVAL_X;
                            end else begin
                                bad_q <= 1'b1;
                            end
                        end
                    end
                    EVAL_X: begin
                        if (x_win) begin
                            win_q   <= 1'b1;
                            if (wins_q != '1) wins_q <= wins_q + 1'b1;
                            state_q <= DONE;
                        end else if (full) begin
                            draw_q  <= 1'b1;
                            if (draws_q != '1) draws_q <= draws_q + 1'b1;
                            state_q <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= ENG_WAIT;
                        end
                    end
                    ENG_WAIT: begin
                        // An ack arriving in the final timeout cycle still counts.
                        if (eng_ack) begin
                            req_q <= 1'b0;
                            if (o_legal) begin
                                o_q     <= o_q | eng_move;
                                state_q <= EVAL_O;
                            end else begin
                                fault_q <= 1'b1;
                                state_q <= DONE;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            req_q   <= 1'b0;
                            fault_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    EVAL_O: begin
                        if (o_win) begin
                            lose_q  <= 1'b1;
                            if (losses_q != '1) losses_q <= losses_q + 1'b1;
                            state_q <= DONE;
                        end else if (full) begin
                            draw_q  <= 1'b1;
                            if (draws_q != '1) draws_q <= draws_q + 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign eng_req   = req_q;
    assign x_board   = x_q;
    assign o_board   = o_q;
    assign busy      = (state_q != IDLE);
    assign bad_move  = bad_q;
    assign win_game  = win_q;
    assign lose_game = lose_q;
    assign draw_game = draw_q;
    assign eng_fault = fault_q;
    assign wins      = wins_q;
    assign losses    = losses_q;
    assign draws     = draws_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer against a transaction-level game model.
module tb_game_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0, new_game = 1'b0, eng_ack = 1'b0;
    logic [8:0] xin = '0, eng_move = '0;
    logic       eng_req, busy, bad_move, win_game, lose_game, draw_game, eng_fault;
    logic [8:0] x_board, o_board;
    logic [3:0] wins, losses, draws;

    always #5 clock = ~clock;

    game_sequencer #(.ENG_TIMEOUT(15), .SCORE_W(4)) dut (
        .clock(clock), .reset(reset), .go(go), .xin(xin), .new_game(new_game),
        .eng_req(eng_req), .eng_ack(eng_ack), .eng_move(eng_move),
        .x_board(x_board), .o_board(o_board), .busy(busy), .bad_move(bad_move),
        .win_game(win_game), .lose_game(lose_game), .draw_game(draw_game),
        .eng_fault(eng_fault), .wins(wins), .losses(losses), .draws(draws)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: board contents, result flags and scores.
    logic [8:0] mx = '0, mo = '0;
    bit         mwin, mlose, mdraw, mfault;
    int         mwins, mlosses, mdraws;

    logic [36:0] obs;
    assign obs = {x_board, o_board, win_game, lose_game, draw_game, eng_fault,
                  busy, eng_req, bad_move, wins, losses, draws};

    function automatic logic [36:0] exp_vec(bit b, bit r, bit bad);
        return {mx, mo, mwin, mlose, mdraw, mfault, b, r, bad,
                4'(mwins), 4'(mlosses), 4'(mdraws)};
    endfunction

    function automatic bit has_line(logic [8:0] b);
        logic [8:0] lines [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                  9'h092, 9'h124, 9'h111, 9'h054};
        for (int i = 0; i < 8; i++)
            if ((b & lines[i]) == lines[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit mdone();
        return mwin | mlose | mdraw | mfault;
    endfunction

    function automatic bit legal(logic [8:0] m);
        return ($countones(m) == 1) && ((m & (mx | mo)) == '0);
    endfunction

    function automatic int sat(int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    function automatic logic [8:0] rand_empty();
        logic [8:0] occ = mx | mo;
        int idx;
        if (occ == 9'h1FF) return '0;
        do idx = $urandom_range(0, 8); while (occ[idx]);
        return 9'(1 << idx);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model(bit scores);
        mx = '0; mo = '0;
        mwin = 0; mlose = 0; mdraw = 0; mfault = 0;
        if (scores) begin mwins = 0; mlosses = 0; mdraws = 0; end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        clear_model(0);
        n_checks++;
        if (obs !== exp_vec(0, 0, 0)) $display("FAIL new_game obs=%h exp=%h", obs, exp_vec(0, 0, 0));
        else n_pass++;
    endtask

    // Submit one X move from IDLE and follow it through the EVAL_X cycle.
    task automatic play_x(logic [8:0] mv);
        bit ok = legal(mv);
        go = 1'b1; xin = mv;
        step();
        go = 1'b0;
        if (!ok) begin
            n_checks++;
            if (obs !== exp_vec(0, 0, 1)) $display("FAIL bad_move obs=%h exp=%h", obs, exp_vec(0, 0, 1));
            else n_pass++;
            step();
            n_checks++;
            if (obs !== exp_vec(0, 0, 0)) $display("FAIL bad_move_clear obs=%h exp=%h", obs, exp_vec(0, 0, 0));
            else n_pass++;
        end else begin
            mx = mx | mv;
            n_checks++;
            if (obs !== exp_vec(1, 0, 0)) $display("FAIL x_placed obs=%h exp=%h", obs, exp_vec(1, 0, 0));
            else n_pass++;
            step();
            if (has_line(mx)) begin mwin = 1; mwins = sat(mwins); end
            else if ((mx | mo) == 9'h1FF) begin mdraw = 1; mdraws = sat(mdraws); end
            n_checks++;
            if (obs !== exp_vec(1, !mdone(), 0)) $display("FAIL eval_x obs=%h exp=%h", obs, exp_vec(1, !mdone(), 0));
            else n_pass++;
        end
    endtask

    // Engine answers after `delay` idle ENG_WAIT cycles; delay >= 15 means never.
    task automatic play_o(int delay, logic [8:0] mv);
        for (int i = 0; i < delay && i < 15; i++) begin
            go  = 1'($urandom_range(0, 1));
            xin = 9'($urandom);
            step();
            if (i == 13) begin
                n_checks++;
                if (obs !== exp_vec(1, 1, 0)) $display("FAIL wait_14 obs=%h exp=%h", obs, exp_vec(1, 1, 0));
                else n_pass++;
            end
        end
        go = 1'b0;
        if (delay >= 15) begin
            mfault = 1;
            n_checks++;
            if (obs !== exp_vec(1, 0, 0)) $display("FAIL timeout obs=%h exp=%h", obs, exp_vec(1, 0, 0));
            else n_pass++;
            return;
        end
        eng_ack = 1'b1; eng_move = mv;
        step();
        eng_ack = 1'b0; eng_move = 9'($urandom);
        if (legal(mv)) begin
            mo = mo | mv;
            n_checks++;
            if (obs !== exp_vec(1, 0, 0)) $display("FAIL o_placed obs=%h exp=%h", obs, exp_vec(1, 0, 0));
            else n_pass++;
            step();
            if (has_line(mo)) begin mlose = 1; mlosses = sat(mlosses); end
            else if ((mx | mo) == 9'h1FF) begin mdraw = 1; mdraws = sat(mdraws); end
            n_checks++;
            if (obs !== exp_vec(mdone(), 0, 0)) $display("FAIL eval_o obs=%h exp=%h", obs, exp_vec(mdone(), 0, 0));
            else n_pass++;
        end else begin
            mfault = 1;
            n_checks++;
            if (obs !== exp_vec(1, 0, 0)) $display("FAIL eng_illegal obs=%h exp=%h", obs, exp_vec(1, 0, 0));
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        clear_model(1);
        n_checks++;
        if (obs !== exp_vec(0, 0, 0)) $display("FAIL reset obs=%h exp=%h", obs, exp_vec(0, 0, 0));
        else n_pass++;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic_turn();
        play_x(9'h001);
        play_o(2, 9'h010);
    endtask

    task automatic test_illegal_x();
        play_x(9'h003);
        play_x(9'h010);
        play_x(9'h000);
    endtask

    task automatic test_ack_ignored();
        eng_ack = 1'b1; eng_move = 9'h100;
        step();
        eng_ack = 1'b0;
        n_checks++;
        if (obs !== exp_vec(0, 0, 0)) $display("FAIL ack_idle obs=%h exp=%h", obs, exp_vec(0, 0, 0));
        else n_pass++;
    endtask

    task automatic win_sequence();
        play_x(9'h001); play_o(0, 9'h008);
        play_x(9'h002); play_o(1, 9'h010);
        play_x(9'h004);
    endtask

    task automatic test_x_wins();
        do_new_game();
        win_sequence();
        go = 1'b1; xin = 9'h100;
        step();
        go = 1'b0;
        n_checks++;
        if (obs !== exp_vec(1, 0, 0)) $display("FAIL go_in_done obs=%h exp=%h", obs, exp_vec(1, 0, 0));
        else n_pass++;
        do_new_game();
    endtask

    task automatic test_timeout();
        play_x(9'h010);
        play_o(15, 9'h000);
        do_new_game();
    endtask

    task automatic test_ack_last_cycle();
        play_x(9'h100);
        play_o(14, 9'h001);
        do_new_game();
    endtask

    task automatic test_draw();
        play_x(9'h001); play_o(0, 9'h002);
        play_x(9'h004); play_o(3, 9'h010);
        play_x(9'h008); play_o(0, 9'h040);
        play_x(9'h020); play_o(5, 9'h100);
        play_x(9'h080);
        do_new_game();
    endtask

    task automatic test_newgame_priority();
        play_x(9'h001);
        step();
        new_game = 1'b1; eng_ack = 1'b1; eng_move = 9'h010;
        step();
        new_game = 1'b0; eng_ack = 1'b0;
        clear_model(0);
        n_checks++;
        if (obs !== exp_vec(0, 0, 0)) $display("FAIL newgame_vs_ack obs=%h exp=%h", obs, exp_vec(0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        play_x(9'h010);
        step(); step(); step();
        #2 reset = 1'b0;
        #1;
        clear_model(1);
        n_checks++;
        if (obs !== exp_vec(0, 0, 0)) $display("FAIL reset_mid_wait obs=%h exp=%h", obs, exp_vec(0, 0, 0));
        else n_pass++;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 16; g++) begin
            do_new_game();
            win_sequence();
        end
        n_checks++;
        if (wins !== 4'd15) $display("FAIL wins_saturate got=%0d want=15", wins);
        else n_pass++;
        do_new_game();
    endtask

    task automatic test_random_games();
        logic [8:0] xm, om;
        int         dly, turns;
        bit         ok;
        for (int g = 0; g < 25; g++) begin
            turns = 0;
            while (!mdone() && turns < 40) begin
                turns++;
                xm = ($urandom_range(0, 3) == 0) ? 9'($urandom) : rand_empty();
                ok = legal(xm);
                play_x(xm);
                if (ok && !mdone()) begin
                    dly = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 14);
                    om  = ($urandom_range(0, 6) == 0) ? 9'($urandom) : rand_empty();
                    play_o(dly, om);
                end
            end
            do_new_game();
        end
    endtask

    initial begin
        test_reset();
        test_basic_turn();
        test_illegal_x();
        test_ack_ignored();
        test_x_wins();
        test_timeout();
        test_ack_last_cycle();
        test_draw();
        test_newgame_priority();
        test_reset_mid_wait();
        test_saturation();
        test_random_games();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
